// File: rtl/sr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues sequential imem requests and buffers in-order responses for decode.
// Optional macro SR_FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module sr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];

  logic credit_s, req_fire_s, rsp_drop_s, push_s, pop_s;

  // Request credit: buffered plus in-flight (including responses to be dropped) never exceeds DEPTH.
  always_comb begin
    credit_s       = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C;
    imem_req_valid = !rst && !redirect && credit_s;
    imem_req_addr  = fetch_pc_q;
    req_fire_s     = imem_req_valid && imem_req_ready;
    rsp_drop_s     = imem_rsp_valid && (drop_cnt_q != {CW{1'b0}});
    pop_s          = (count_q != {CW{1'b0}}) && instr_ready && !redirect;
  end

  // Decode-side view of the queue head, and whether the incoming response must be stored.
  always_comb begin
`ifdef SR_FETCH_BYPASS_EN
    if (!rst && !redirect && imem_rsp_valid && (count_q == {CW{1'b0}}) &&
        (drop_cnt_q == {CW{1'b0}})) begin
      instr_valid = 1'b1;
      instr       = imem_rsp_data;
      instr_pc    = rsp_pc_q;
      push_s      = !instr_ready;
    end else begin
      instr_valid = !rst && (count_q != {CW{1'b0}});
      instr       = data_q[rd_ptr_q];
      instr_pc    = pc_q[rd_ptr_q];
      push_s      = imem_rsp_valid && !rsp_drop_s;
    end
`else
    instr_valid = !rst && (count_q != {CW{1'b0}});
    instr       = data_q[rd_ptr_q];
    instr_pc    = pc_q[rd_ptr_q];
    push_s      = imem_rsp_valid && !rsp_drop_s;
`endif
  end

  // Next-state: redirect wins; in-flight requests at redirect become responses to discard.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (redirect) begin
      fetch_pc_d    = redirect_pc;
      rsp_pc_d      = redirect_pc;
      count_d       = {CW{1'b0}};
      wr_ptr_d      = {AW{1'b0}};
      rd_ptr_d      = {AW{1'b0}};
      outstanding_d = outstanding_q - CW'(imem_rsp_valid);
      drop_cnt_d    = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (imem_rsp_valid && !rsp_drop_s) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(imem_rsp_valid);
      drop_cnt_d    = drop_cnt_q - CW'(rsp_drop_s);
      count_d       = count_q + CW'(push_s) - CW'(pop_s);
      wr_ptr_d      = wr_ptr_q + AW'(push_s);
      rd_ptr_d      = rd_ptr_q + AW'(pop_s);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= {CW{1'b0}};
      outstanding_q <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Queue storage; contents are only meaningful below count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && !redirect && push_s) begin
      data_q[wr_ptr_q] <= imem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding_q != {CW{1'b0}}));
  credit_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_q} + {1'b0, outstanding_q}) <= DEPTH_C);
  drop_bound: assert property (@(posedge clk) disable iff (rst)
    drop_cnt_q <= outstanding_q);
endmodule

// File: tb/tb_sr_fetch_queue.sv
// Directed bench for sr_fetch_queue: bench-side memory model with programmable latency, hand-derived expectations.
module tb_sr_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;

  always #5 clk = ~clk;

  sr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  int checks = 0;
  int failures = 0;
  int cyc, lat, n_acc, first_rsp, first_iv, n_pre;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] log_pc[$], log_data[$];
  logic        rst_k, ready_k, iready_k, redir_k;
  logic [31:0] rpc_k;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] get_pc(input int i);
    if (i < log_pc.size()) return log_pc[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] get_data(input int i);
    if (i < log_data.size()) return log_data[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, let logic settle, record what the next posedge will do.
  task automatic step();
    @(negedge clk);
    rst = rst_k; imem_req_ready = ready_k; instr_ready = iready_k;
    redirect = redir_k; redirect_pc = rpc_k;
    if (!rst_k && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = word_of(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    end
    #1;
    if (rst_k) begin
      mq_addr.delete(); mq_due.delete();
    end else begin
      if (imem_rsp_valid) begin
        void'(mq_addr.pop_front()); void'(mq_due.pop_front());
        if (first_rsp < 0) first_rsp = cyc;
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr); mq_due.push_back(cyc + lat); n_acc++;
      end
      if (instr_valid && first_iv < 0) first_iv = cyc;
      if (instr_valid && instr_ready && !redirect) begin
        log_pc.push_back(instr_pc); log_data.push_back(instr);
      end
    end
    cyc++;
  endtask

  task automatic clear_log();
    cyc = 0; n_acc = 0; first_rsp = -1; first_iv = -1;
    log_pc.delete(); log_data.delete();
  endtask

  task automatic do_reset(input int l);
    lat = l; rst_k = 1'b1; redir_k = 1'b0; rpc_k = 32'h0;
    step(); step();
    rst_k = 1'b0;
    clear_log();
  endtask

  initial begin
    ready_k = 1'b1; iready_k = 1'b1; rst_k = 1'b1; redir_k = 1'b0; rpc_k = 32'h0;
    lat = 1; clear_log();

    // Reset state and straight-line fetch with 1-cycle memory
    step();
    check_val("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_val("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    do_reset(1);
    step();
    check_val("t1_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_val("t1_req_addr", imem_req_addr, 32'h0);
    check_val("t1_iv_c0", {31'h0, instr_valid}, 32'h0);
    repeat (12) step();
    check_val("t1_first_rsp", first_rsp, 32'd1);
`ifdef SR_FETCH_BYPASS_EN
    check_val("t1_first_iv", first_iv, 32'd1);
`else
    check_val("t1_first_iv", first_iv, 32'd2);
`endif
    for (int i = 0; i < 6; i++) begin
      check_val("t1_pc", get_pc(i), 32'(4 * i));
      check_val("t1_data", get_data(i), word_of(32'(4 * i)));
    end

    // Decoder stalled: credit limit stops at DEPTH requests, then drains in order
    iready_k = 1'b0;
    do_reset(1);
    repeat (10) step();
    check_val("t2_n_acc", n_acc, 32'd4);
    check_val("t2_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_val("t2_req_addr", imem_req_addr, 32'h10);
    check_val("t2_no_pop", log_pc.size(), 32'd0);
    iready_k = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 5; i++) check_val("t2_pc", get_pc(i), 32'(4 * i));

    // Redirect with three requests in flight: stale responses dropped
    do_reset(4);
    repeat (3) step();
    check_val("t3_n_acc", n_acc, 32'd3);
    redir_k = 1'b1; rpc_k = 32'h100;
    step();
    check_val("t3_no_req_in_redirect", {31'h0, imem_req_valid}, 32'h0);
    redir_k = 1'b0;
    repeat (16) step();
    check_val("t3_pc0", get_pc(0), 32'h100);
    check_val("t3_pc1", get_pc(1), 32'h104);
    check_val("t3_data1", get_data(1), word_of(32'h104));

    // Redirect coinciding with a response and a pop attempt
    do_reset(2);
    repeat (4) step();
    n_pre = log_pc.size();
    redir_k = 1'b1; rpc_k = 32'h200;
    step();
`ifdef SR_FETCH_BYPASS_EN
    check_val("t4_iv_redirect", {31'h0, instr_valid}, 32'h0);
`else
    check_val("t4_iv_redirect", {31'h0, instr_valid}, 32'h1);
`endif
    redir_k = 1'b0;
    step();
    check_val("t4_iv_after", {31'h0, instr_valid}, 32'h0);
    check_val("t4_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_val("t4_req_addr", imem_req_addr, 32'h200);
    repeat (8) step();
    check_val("t4_pc0", get_pc(n_pre), 32'h200);
    check_val("t4_pc1", get_pc(n_pre + 1), 32'h204);

    // Redirect near the top of the address space: PC wraps to zero
    do_reset(1);
    redir_k = 1'b1; rpc_k = 32'hFFFF_FFF8;
    step();
    redir_k = 1'b0;
    repeat (8) step();
    check_val("t5_pc0", get_pc(0), 32'hFFFF_FFF8);
    check_val("t5_pc1", get_pc(1), 32'hFFFF_FFFC);
    check_val("t5_pc2", get_pc(2), 32'h0000_0000);
    check_val("t5_data2", get_data(2), word_of(32'h0));

    // Reset in the middle of operation discards queue and in-flight state
    iready_k = 1'b0;
    do_reset(2);
    repeat (5) step();
    check_val("t6_iv_before", {31'h0, instr_valid}, 32'h1);
    check_val("t6_req_before", {31'h0, imem_req_valid}, 32'h0);
    rst_k = 1'b1;
    step();
    check_val("t6_iv_in_rst", {31'h0, instr_valid}, 32'h0);
    check_val("t6_req_in_rst", {31'h0, imem_req_valid}, 32'h0);
    rst_k = 1'b0;
    clear_log();
    step();
    check_val("t6_iv_after", {31'h0, instr_valid}, 32'h0);
    check_val("t6_req_valid_after", {31'h0, imem_req_valid}, 32'h1);
    check_val("t6_req_addr_after", imem_req_addr, 32'h0);
    iready_k = 1'b1;
    repeat (6) step();
    check_val("t6_pc0", get_pc(0), 32'h0);
    check_val("t6_pc1", get_pc(1), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
